// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_wt #(
  parameter int NBITS  = 8,
  parameter int NLINES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-1:2] Address,
  input  logic [NBITS-1:0] WriteData,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [NBITS-1:0] ReadData,
  output logic             Stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [NBITS-1:2] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  input  logic [NBITS-1:0] mem_rdata,
  input  logic             mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
`endif
);

  localparam int IDX  = $clog2(NLINES);
  localparam int TAGW = NBITS - 2 - IDX;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WTHRU = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:2] addr_q, addr_d;
  logic [NBITS-1:0] wdata_q, wdata_d;
  logic [NBITS-1:0] rdata_q;
  logic [NLINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_mem  [NLINES];
  logic [NBITS-1:0] data_mem [NLINES];

  logic [IDX-1:0]   idx_s, fill_idx_s;
  logic [TAGW-1:0]  tag_s;
  logic             hit_s, fill_we_s, wr_hit_s;
  logic [NBITS-1:0] rd_s;

  assign idx_s      = Address[IDX+1:2];
  assign tag_s      = Address[NBITS-1:IDX+2];
  assign fill_idx_s = addr_q[IDX+1:2];
  assign hit_s      = valid_q[idx_s] && (tag_mem[idx_s] == tag_s);

  // Next-state and output decode; backing-memory outputs depend only on state and latches.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_s      = rdata_q;
    Stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_we_s = 1'b0;
    wr_hit_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemWrite) begin
          Stall    = 1'b1;
          addr_d   = Address;
          wdata_d  = WriteData;
          wr_hit_s = hit_s;
          state_d  = WTHRU;
        end else if (MemRead) begin
          if (hit_s) begin
            rd_s = data_mem[idx_s];
          end else begin
            Stall   = 1'b1;
            addr_d  = Address;
            state_d = FILL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        Stall    = ~mem_ack;
        if (mem_ack) begin
          rd_s      = mem_rdata;
          fill_we_s = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = FILL;
        end
      end
      WTHRU: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        Stall     = ~mem_ack;
        if (mem_ack) begin
          state_d = IDLE;
        end else begin
          state_d = WTHRU;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ReadData = rd_s;

  // Control state, latches, read-data hold and valid bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rd_s;
      if (fill_we_s) begin
        valid_q[fill_idx_s] <= 1'b1;
      end
    end
  end

  // Tag/data arrays are not reset; a reset cycle suppresses every array write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (fill_we_s) begin
        tag_mem[fill_idx_s]  <= addr_q[NBITS-1:IDX+2];
        data_mem[fill_idx_s] <= mem_rdata;
      end else if (wr_hit_s) begin
        data_mem[idx_s] <= WriteData;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic hit_evt_s, miss_evt_s;
  assign hit_evt_s  = (state_q == IDLE) && MemRead && !MemWrite && hit_s;
  assign miss_evt_s = (state_q == IDLE) && (state_d == FILL);

  // Saturating statistics counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else begin
      if (hit_evt_s && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'h0001;
      end
      if (miss_evt_s && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Randomized bench for dcache_wt: a line-level cache model plus a shadow backing memory
// predict every output each cycle; directed scenarios pin the model with literal values.
module tb_dcache_wt;
  localparam int NB = 8;
  localparam int NL = 4;
  localparam int AW = NB - 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [NB-1:2] Address;
  logic [NB-1:0] WriteData;
  logic          MemRead, MemWrite;
  logic [NB-1:0] ReadData;
  logic          Stall, mem_req, mem_we;
  logic [NB-1:2] mem_addr;
  logic [NB-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
`ifdef DCACHE_STATS_EN
  logic [15:0]   hit_count, miss_count;
`endif

  dcache_wt #(.NBITS(NB), .NLINES(NL)) dut (
    .clock(clock), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData), .Stall(Stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model: each line remembers which word address it holds.
  bit            m_valid [NL];
  logic [AW-1:0] m_line  [NL];
  logic [NB-1:0] m_data  [NL];
  logic [NB-1:0] shadow  [1<<AW];
  bit            p_rd, p_wr;
  logic [AW-1:0] p_addr;
  logic [NB-1:0] p_data;
  int            p_cnt;
  logic [NB-1:0] m_hold;
  bit            m_last_stall;
  int            m_hits, m_misses;

  int ack_delay = 0;
  bit spur_en   = 1'b0;
  bit scramble  = 1'b0;

  // Captures of what the DUT did during the last operation.
  int            cap_stall;
  bit            cap_req, cap_we;
  logic [AW-1:0] cap_addr;
  logic [NB-1:0] cap_wdata, cap_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hit();
    int i;
    i = int'(Address) % NL;
    return m_valid[i] && (m_line[i] == Address);
  endfunction

  function automatic void model_out(output bit stall, output logic [NB-1:0] rd,
                                    output bit req, output bit we);
    int i;
    i = int'(Address) % NL;
    stall = 1'b0; rd = m_hold; req = 1'b0; we = 1'b0;
    if (p_rd) begin
      req = 1'b1; stall = !mem_ack;
      if (mem_ack) rd = mem_rdata;
    end else if (p_wr) begin
      req = 1'b1; we = 1'b1; stall = !mem_ack;
    end else if (MemWrite) begin
      stall = 1'b1;
    end else if (MemRead) begin
      if (model_hit()) rd = m_data[i];
      else stall = 1'b1;
    end
  endfunction

  bit            pe_stall, pe_req, pe_we;
  logic [NB-1:0] pe_rd;

  // Model update at each active edge.
  always @(posedge clock) begin
    model_out(pe_stall, pe_rd, pe_req, pe_we);
    if (reset) begin
      for (int i = 0; i < NL; i++) m_valid[i] <= 1'b0;
      p_rd <= 1'b0; p_wr <= 1'b0; p_addr <= '0; p_data <= '0; p_cnt <= 0;
      m_hold <= '0; m_last_stall <= 1'b0; m_hits <= 0; m_misses <= 0;
    end else begin
      m_hold <= pe_rd;
      m_last_stall <= pe_stall;
      if (p_rd || p_wr) begin
        if (mem_ack) begin
          if (p_rd) begin
            m_valid[int'(p_addr) % NL] <= 1'b1;
            m_line[int'(p_addr) % NL]  <= p_addr;
            m_data[int'(p_addr) % NL]  <= mem_rdata;
          end else begin
            shadow[p_addr] <= p_data;
          end
          p_rd <= 1'b0; p_wr <= 1'b0;
        end else begin
          p_cnt <= p_cnt + 1;
        end
      end else if (MemWrite) begin
        if (model_hit()) m_data[int'(Address) % NL] <= WriteData;
        p_wr <= 1'b1; p_addr <= Address; p_data <= WriteData; p_cnt <= 0;
      end else if (MemRead) begin
        if (model_hit()) begin
          if (m_hits != 65535) m_hits <= m_hits + 1;
        end else begin
          if (m_misses != 65535) m_misses <= m_misses + 1;
          p_rd <= 1'b1; p_addr <= Address; p_cnt <= 0;
        end
      end
    end
  end

  bit            ne_stall, ne_req, ne_we;
  logic [NB-1:0] ne_rd;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      model_out(ne_stall, ne_rd, ne_req, ne_we);
      chk("Stall", 32'(Stall), 32'(ne_stall));
      chk("ReadData", 32'(ReadData), 32'(ne_rd));
      chk("mem_req", 32'(mem_req), 32'(ne_req));
      if (ne_req) begin
        chk("mem_we", 32'(mem_we), 32'(ne_we));
        chk("mem_addr", 32'(mem_addr), 32'(p_addr));
        if (ne_we) chk("mem_wdata", 32'(mem_wdata), 32'(p_data));
      end
      if (p_rd && mem_ack) chk("fill_coherent", 32'(ReadData), 32'(shadow[p_addr]));
`ifdef DCACHE_STATS_EN
      chk("hit_count", 32'(hit_count), 32'(m_hits));
      chk("miss_count", 32'(miss_count), 32'(m_misses));
`endif
      if (Stall) cap_stall <= cap_stall + 1;
      if (mem_req) begin
        cap_req <= 1'b1; cap_addr <= mem_addr; cap_we <= mem_we; cap_wdata <= mem_wdata;
      end
      cap_rd <= ReadData;
    end
  end

  // Advance one cycle and play the backing memory.
  task automatic tick();
    @(posedge clock);
    #1;
    if ((p_rd || p_wr) && (p_cnt == ack_delay)) begin
      mem_ack   = 1'b1;
      mem_rdata = p_rd ? shadow[p_addr] : NB'($urandom);
    end else begin
      mem_ack   = (spur_en && !(p_rd || p_wr) && ($urandom_range(0, 4) == 0));
      mem_rdata = NB'($urandom);
    end
  endtask

  task automatic do_op(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [NB-1:0] d, input int dly);
    bit done;
    done = 1'b0;
    ack_delay = dly;
    MemRead = rd; MemWrite = wr; Address = a; WriteData = d;
    cap_stall = 0; cap_req = 1'b0; cap_we = 1'b0; cap_addr = '0; cap_wdata = '0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (!p_rd && !p_wr && !m_last_stall) begin
        done = 1'b1;
        break;
      end
      if (scramble) begin
        MemRead = 1'($urandom); MemWrite = 1'($urandom);
        Address = AW'($urandom); WriteData = NB'($urandom);
      end
    end
    chk("op_done", 32'(done), 32'd1);
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < (1 << AW); i++) shadow[i] = NB'($urandom);
    shadow[5] = 8'h3C;
    shadow[9] = 8'h77;
    repeat (2) tick();
    reset = 1'b0;
    #3;
    chk("rst_ReadData", 32'(ReadData), 32'h0);
    chk("rst_Stall", 32'(Stall), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);

    // Cold read miss, then hit.
    do_op(1'b1, 1'b0, 6'h05, 8'h00, 3);
    chk("s1_stall_cycles", 32'(cap_stall), 32'd4);
    chk("s1_rdata", 32'(cap_rd), 32'h3C);
    chk("s1_mem_addr", 32'(cap_addr), 32'h05);
    chk("s1_mem_we", 32'(cap_we), 32'h0);
    do_op(1'b1, 1'b0, 6'h05, 8'h00, 0);
    chk("s1_hit_stall", 32'(cap_stall), 32'd0);
    chk("s1_hit_req", 32'(cap_req), 32'd0);
    chk("s1_hit_rdata", 32'(cap_rd), 32'h3C);

    // Conflict eviction on index 1.
    do_op(1'b1, 1'b0, 6'h09, 8'h00, 1);
    chk("s2_fill_req", 32'(cap_req), 32'd1);
    chk("s2_fill_rdata", 32'(cap_rd), 32'h77);
    do_op(1'b1, 1'b0, 6'h05, 8'h00, 0);
    chk("s2_evict_req", 32'(cap_req), 32'd1);
    chk("s2_evict_addr", 32'(cap_addr), 32'h05);
`ifdef DCACHE_STATS_EN
    #3;
    chk("stats_hits", 32'(hit_count), 32'd1);
    chk("stats_misses", 32'(miss_count), 32'd3);
`endif

    // Write hit updates line and goes through.
    do_op(1'b0, 1'b1, 6'h05, 8'hA7, 2);
    chk("s3_stall_cycles", 32'(cap_stall), 32'd3);
    chk("s3_mem_we", 32'(cap_we), 32'd1);
    chk("s3_mem_wdata", 32'(cap_wdata), 32'hA7);
    do_op(1'b1, 1'b0, 6'h05, 8'h00, 0);
    chk("s3_hit_req", 32'(cap_req), 32'd0);
    chk("s3_hit_rdata", 32'(cap_rd), 32'hA7);

    // Write miss does not allocate.
    do_op(1'b0, 1'b1, 6'h02, 8'h11, 0);
    chk("s4_wthru_we", 32'(cap_we), 32'd1);
    do_op(1'b1, 1'b0, 6'h02, 8'h00, 1);
    chk("s4_miss_req", 32'(cap_req), 32'd1);
    chk("s4_miss_we", 32'(cap_we), 32'd0);
    chk("s4_rdata", 32'(cap_rd), 32'h11);

    // Reset during FILL coincident with ack.
    MemRead = 1'b1; Address = 6'h06; ack_delay = 1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; MemRead = 1'b0;
    #3;
    chk("s5_stall", 32'(Stall), 32'h0);
    chk("s5_mem_req", 32'(mem_req), 32'h0);
    do_op(1'b1, 1'b0, 6'h05, 8'h00, 0);
    chk("s5_05_miss", 32'(cap_req), 32'd1);
    chk("s5_05_rdata", 32'(cap_rd), 32'hA7);
    do_op(1'b1, 1'b0, 6'h06, 8'h00, 0);
    chk("s5_06_miss", 32'(cap_req), 32'd1);

    // Randomized traffic with spurious idle acks and scrambled inputs while busy.
    spur_en = 1'b1;
    scramble = 1'b1;
    for (int k = 0; k < 500; k++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else if (kind <= 2) begin
        do_op(1'b0, 1'b0, AW'($urandom), NB'($urandom), 0);
      end else begin
        do_op(kind >= 5 || kind == 3, kind <= 4 || kind == 9,
              AW'($urandom_range(0, 11)), NB'($urandom), $urandom_range(0, 4));
      end
    end
    spur_en = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache, one word per line.
- Sits directly downstream of the datapath's memory port. Consumes the datapath's word Address and WriteData, returns ReadData.
- Raises Stall to the controller while a request is serviced by a slower backing memory over a req/ack handshake.

Parameters:
- NBITS, 8, data word width and byte-address width.
- NLINES, 4, number of cache lines; power of two, at least 2.
- Derived: IDX = $clog2(NLINES), TAGW = NBITS-2-IDX.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- Address  in  NBITS-2 (NBITS-1:2)  word address from the datapath.
- WriteData  in  NBITS  store data from the datapath.
- MemRead  in  1  load request this cycle.
- MemWrite  in  1  store request this cycle.
- ReadData  out  NBITS  load data to the datapath.
- Stall  out  1  controller must hold PC and the request while high.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  NBITS-2  backing word address.
- mem_wdata  out  NBITS  backing write data.
- mem_rdata  in  NBITS  backing read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.

Behaviour:
- Index = Address[IDX+1:2]; tag = Address[NBITS-1:IDX+2]. Per line: valid bit, tag, data word.
- FSM states: IDLE, FILL, WTHRU.
- Reset: state=IDLE, all valid=0, latched address/data=0. Outputs: Stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadData=0. Tag and data arrays are not reset.
- MemRead and MemWrite both high is treated as a write.
- IDLE, read hit:
  - ReadData = line data combinationally, same cycle.
  - Stall=0, no state change.
- IDLE, read miss:
  - Stall=1 combinationally.
  - Latch Address; next state FILL.
- IDLE, write (hit or miss):
  - Stall=1.
  - Latch Address and WriteData; next state WTHRU.
  - On a hit, the line data is updated at this edge. On a miss, no allocation and the line is untouched.
- IDLE, no request: ReadData holds the last value driven; Stall=0.
- FILL:
  - mem_req=1, mem_we=0, mem_addr=latched address.
  - Stall = !mem_ack.
  - On mem_ack: ReadData = mem_rdata in the same cycle. The line is written with valid=1, latched tag and mem_rdata. Next state IDLE.
- WTHRU:
  - mem_req=1, mem_we=1, mem_addr and mem_wdata from the latches.
  - Stall = !mem_ack. On mem_ack, next state IDLE.
- mem_req, mem_addr, mem_wdata and mem_we are decoded from state and latches only. They stay stable until ack, independent of datapath inputs.
- Latency:
  - Read hit: 0 stall cycles.
  - Miss or write: minimum 1 stall cycle (the IDLE cycle), plus one FILL/WTHRU cycle per cycle until mem_ack. The ack cycle itself is not stalled.
- mem_ack seen in IDLE is ignored.
- Datapath inputs changing during FILL/WTHRU have no effect. The controller re-presents the same request after Stall falls; a read hit on it is then served combinationally.
- Reset during FILL/WTHRU:
  - Abort: next cycle IDLE, mem_req=0, all lines invalid.
  - No line is written even if mem_ack coincides with reset.
- Conflict: a fill overwrites the indexed line regardless of its previous tag or valid state.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: adds outputs hit_count and miss_count, 16 bits each.
  - Counters are reset to 0 and saturate at 16'hFFFF.
  - hit_count increments on each IDLE read-hit cycle.
  - miss_count increments on each IDLE->FILL transition.
  - Writes count in neither.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold read miss: after reset, MemRead with Address=6'h05; memory acks 3 cycles after mem_req rises with mem_rdata=8'h3C -> mem_addr=6'h05, mem_we=0, Stall high 4 cycles, ReadData=8'h3C on the ack cycle. A repeated read of 6'h05 then hits with Stall=0 and mem_req=0.
- Conflict eviction: after scenario 1, read 6'h09 (index 1, tag 2, data 8'h77) misses and fills. A following read of 6'h05 misses again and issues mem_req with mem_addr=6'h05.
- Write hit: with 6'h05 cached, write 8'hA7 to 6'h05, ack after 2 cycles -> mem_we=1, mem_wdata=8'hA7, Stall high 3 cycles. A later read of 6'h05 hits and returns 8'hA7 with no mem_req.
- Write miss, no allocate: write 8'h11 to 6'h02 (index 2 invalid) -> write-through occurs. A subsequent read of 6'h02 misses (mem_req=1, mem_we=0).
- Reset mid-fill: assert reset for 1 cycle while in FILL, coincident with mem_ack -> next cycle Stall=0 and mem_req=0. A read of the previously cached 6'h05 misses.
- Stats (DCACHE_STATS_EN): run scenarios 1–2 -> hit_count=1, miss_count=3. Forcing miss_count to 16'hFFFF and adding one more miss leaves it at 16'hFFFF.
